// File: rtl/blink_pkg.sv
// Shared types and helpers for the status-LED pattern sequencer.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int LOOP_W = 8;
    localparam int DIM_W  = 4;

    // 64-bit product so large FREQ*STEP_MS combinations do not overflow.
    function automatic longint calc_period(input longint freq, input longint step_ms);
        return (freq * step_ms) / 1000;
    endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Step prescaler: counts 0..PERIOD-1 and pulses tick_o on the last count; held at 0 by clear_i.
module blink_tick_gen
    import blink_pkg::*;
#(
    parameter int PERIOD = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = 1'b0;
        cnt_d  = cnt_q + CNT_W'(1);
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            tick_o = 1'b1;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/blink_pattern_ctrl.sv
// Status-LED pattern sequencer: accepts a bit pattern by valid/ready and replays it a set number of loops.
// Optional brightness PWM on lit steps is enabled by defining BLINK_DIM_EN.
module blink_pattern_ctrl
    import blink_pkg::*;
#(
    parameter int FREQ    = 50_000_000,
    parameter int STEP_MS = 100,
    parameter int STEPS   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       pat_valid_i,
    output logic                       pat_ready_o,
    input  logic [STEPS-1:0]           pat_bits_i,
    input  logic [$clog2(STEPS):0]     pat_len_i,
    input  logic [LOOP_W-1:0]          pat_loops_i,
    input  logic                       abort_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       led_o
`ifdef BLINK_DIM_EN
    ,
    input  logic [DIM_W-1:0]           dim_i
`endif
);

    localparam longint PERIOD_L = calc_period(longint'(FREQ), longint'(STEP_MS));
    localparam int     PERIOD   = int'(PERIOD_L);
    localparam int     LEN_W    = $clog2(STEPS) + 1;
    localparam int     STEP_W   = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (PERIOD_L <= 0) begin : g_period_chk
        $fatal(1, "blink_pattern_ctrl: step period evaluates to zero cycles");
    end

    // Zero length plays one step; anything past STEPS plays the whole register.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len == '0) return LEN_W'(1);
        if (int'(len) > STEPS) return LEN_W'(STEPS);
        return len;
    endfunction

    state_e             state_q, state_d;
    logic [STEPS-1:0]   bits_q, bits_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LOOP_W-1:0]  loops_q, loops_d;
    logic [LOOP_W-1:0]  loop_q, loop_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               rdy_en_q, rdy_en_d;
    logic               tick;
    logic               tick_clear;
    logic               step_bit;
    logic               last_step;

    assign tick_clear = (state_q != RUN);

    blink_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick_gen (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (tick_clear),
        .tick_o  (tick)
    );

    // rdy_en_q keeps ready low through reset and the edge that releases it.
    assign pat_ready_o = (state_q == IDLE) && rdy_en_q;
    assign busy_o      = (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign step_bit    = bits_q[step_q];
    assign last_step   = (LEN_W'(step_q) == (len_q - LEN_W'(1)));

    always_comb begin
        state_d  = state_q;
        bits_d   = bits_q;
        len_d    = len_q;
        loops_d  = loops_q;
        loop_d   = loop_q;
        step_d   = step_q;
        rdy_en_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (pat_valid_i && pat_ready_o) begin
                    bits_d  = pat_bits_i;
                    len_d   = clamp_len(pat_len_i);
                    loops_d = pat_loops_i;
                    loop_d  = '0;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    step_d  = '0;
                    loop_d  = '0;
                    state_d = IDLE;
                end else if (tick) begin
                    if (last_step) begin
                        step_d = '0;
                        if ((loops_q != '0) && ((loop_q + LOOP_W'(1)) == loops_q)) begin
                            state_d = DONE;
                        end
                        // Endless playback parks the loop count at its maximum.
                        loop_d = (loop_q == '1) ? loop_q : loop_q + LOOP_W'(1);
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            bits_q   <= '0;
            len_q    <= '0;
            loops_q  <= '0;
            loop_q   <= '0;
            step_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bits_q   <= bits_d;
            len_q    <= len_d;
            loops_q  <= loops_d;
            loop_q   <= loop_d;
            step_q   <= step_d;
            rdy_en_q <= rdy_en_d;
        end
    end

`ifdef BLINK_DIM_EN
    logic [DIM_W-1:0] pwm_cnt_q, pwm_cnt_d;

    assign pwm_cnt_d = pwm_cnt_q + DIM_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign led_o = (state_q == RUN) && step_bit && (pwm_cnt_q <= dim_i);
`else
    assign led_o = (state_q == RUN) && step_bit;
`endif

endmodule

// File: tb/tb_blink_pattern_ctrl.sv
// Directed bench for blink_pattern_ctrl with FREQ=1000, STEP_MS=4 (4-cycle steps), STEPS=16.
module tb_blink_pattern_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        pat_valid;
    logic        pat_ready;
    logic [15:0] pat_bits;
    logic [4:0]  pat_len;
    logic [7:0]  pat_loops;
    logic        abort;
    logic        busy;
    logic        done;
    logic        led;
    logic [3:0]  dim;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    blink_pattern_ctrl #(
        .FREQ    (1000),
        .STEP_MS (4),
        .STEPS   (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .pat_valid_i (pat_valid),
        .pat_ready_o (pat_ready),
        .pat_bits_i  (pat_bits),
        .pat_len_i   (pat_len),
        .pat_loops_i (pat_loops),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .led_o       (led)
`ifdef BLINK_DIM_EN
        ,
        .dim_i       (dim)
`endif
    );

    typedef struct {
        logic [15:0] bits;
        logic [4:0]  len;
        logic [7:0]  loops;
        int          steps;  // effective pattern length after clamping
        int          run;    // RUN cycles before done_o
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic offer(input logic [15:0] b, input logic [4:0] l, input logic [7:0] n);
        pat_bits  = b;
        pat_len   = l;
        pat_loops = n;
        pat_valid = 1'b1;
        tick();
        pat_valid = 1'b0;
    endtask

    task automatic play(input vec_t v, input string nm);
        chk({nm, "_ready_before"}, 32'(pat_ready), 32'd1);
        offer(v.bits, v.len, v.loops);
        for (int c = 1; c <= v.run; c++) begin
            chk({nm, "_busy"}, 32'(busy), 32'd1);
            chk({nm, "_led"}, 32'(led), 32'(v.bits[((c - 1) / 4) % v.steps]));
            chk({nm, "_no_done"}, 32'(done), 32'd0);
            tick();
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_done_led"}, 32'(led), 32'd0);
        chk({nm, "_done_busy"}, 32'(busy), 32'd0);
        tick();
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        chk({nm, "_ready_after"}, 32'(pat_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{bits: 16'h0005, len: 5'd4,  loops: 8'd1, steps: 4,  run: 16};
        vecs[1] = '{bits: 16'h0001, len: 5'd0,  loops: 8'd2, steps: 1,  run: 8};
        vecs[2] = '{bits: 16'hA5C3, len: 5'd20, loops: 8'd1, steps: 16, run: 64};
        vecs[3] = '{bits: 16'h0006, len: 5'd3,  loops: 8'd2, steps: 3,  run: 24};
        vecs[4] = '{bits: 16'hFFFF, len: 5'd16, loops: 8'd1, steps: 16, run: 64};

        rst_ni    = 1'b0;
        pat_valid = 1'b0;
        pat_bits  = '0;
        pat_len   = '0;
        pat_loops = '0;
        abort     = 1'b0;
        dim       = 4'd15;

        // Reset state
        for (int i = 0; i < 5; i++) tick();
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(pat_ready), 32'd0);
        rst_ni = 1'b1;
        tick();
        chk("rst_release_ready", 32'(pat_ready), 32'd1);

        // Table-driven patterns
        for (int i = 0; i < 5; i++) play(vecs[i], $sformatf("vec%0d", i));

        // Endless playback, well past loop-counter saturation, then abort
        offer(16'h0001, 5'd2, 8'd0);
        for (int c = 1; c <= 2100; c++) begin
            chk("fwd_led", 32'(led), 32'(((c - 1) / 4) % 2 == 0));
            chk("fwd_no_done", 32'(done), 32'd0);
            tick();
        end
        abort = 1'b1;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        tick();
        abort = 1'b0;
        chk("abort_led", 32'(led), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(pat_ready), 32'd1);
        tick();
        chk("abort_no_done_later", 32'(done), 32'd0);

        // Offer held during RUN: ignored until the cycle after done_o
        offer(16'h0005, 5'd4, 8'd1);
        pat_bits  = 16'h000A;
        pat_len   = 5'd4;
        pat_loops = 8'd1;
        pat_valid = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            chk("hold_ready_run", 32'(pat_ready), 32'd0);
            chk("hold_led_old", 32'(led), 32'(((c - 1) / 4) % 2 == 0));
            tick();
        end
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_ready_done", 32'(pat_ready), 32'd0);
        tick();
        chk("hold_ready_idle", 32'(pat_ready), 32'd1);
        tick();
        pat_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk("hold_busy_new", 32'(busy), 32'd1);
            chk("hold_led_new", 32'(led), 32'(((c - 1) / 4) % 2 == 1));
            tick();
        end
        chk("hold_done_new", 32'(done), 32'd1);
        tick();

        // Reset in the middle of a run ends it silently
        offer(16'h00FF, 5'd8, 8'd3);
        for (int c = 0; c < 5; c++) tick();
        chk("midrst_busy_pre", 32'(busy), 32'd1);
        rst_ni = 1'b0;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_led", 32'(led), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_ready", 32'(pat_ready), 32'd0);
        rst_ni = 1'b1;
        tick();
        chk("midrst_done_after", 32'(done), 32'd0);
        chk("midrst_ready_after", 32'(pat_ready), 32'd1);

`ifdef BLINK_DIM_EN
        // Dimmed all-on pattern: lit 4 of every 16 cycles
        begin
            int on_cnt;
            on_cnt = 0;
            dim = 4'd3;
            offer(16'hFFFF, 5'd16, 8'd1);
            for (int c = 1; c <= 64; c++) begin
                if (led) on_cnt++;
                tick();
            end
            chk("dim_on_count", 32'(on_cnt), 32'd16);
            chk("dim_done", 32'(done), 32'd1);
            dim = 4'd15;
            tick();
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
